// File: rtl/porta_or_pkg.sv
// Shared constants for porta_or_struct: counter width default and {a,b} combination indices.
package porta_or_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [1:0] COMB_00 = 2'd0;
  localparam logic [1:0] COMB_01 = 2'd1;
  localparam logic [1:0] COMB_10 = 2'd2;
  localparam logic [1:0] COMB_11 = 2'd3;

  // One-hot coverage bit for an {a,b} combination
  function automatic logic [3:0] comb_bit(input logic [1:0] idx);
    logic [3:0] r;
    r = 4'b0000;
    case (idx)
      COMB_00: r = 4'b0001;
      COMB_01: r = 4'b0010;
      COMB_10: r = 4'b0100;
      COMB_11: r = 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/or2_gate.sv
// Structural two-input OR built from a gate primitive.
module or2_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  or u_or (y, a, b);

endmodule

// File: rtl/porta_or_struct.sv
// OR gate with registered output, rise pulse, high-cycle counter and input coverage mask.
// Macro PORTA_OR_CNT_EN enables the saturating y_cnt counter; otherwise y_cnt is tied to zero.
module porta_or_struct
  import porta_or_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             y,
  output logic             y_q,
  output logic             y_rise,
  output logic [CNT_W-1:0] y_cnt,
  output logic [3:0]       seen,
  output logic             all_seen
);

  logic y_q_d;

  or2_gate u_or2 (
    .a (a),
    .b (b),
    .y (y)
  );

  // y_rise compares registered y_q against its own previous value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q    <= 1'b0;
      y_q_d  <= 1'b0;
      y_rise <= 1'b0;
    end else begin
      y_q    <= y;
      y_q_d  <= y_q;
      y_rise <= y_q & ~y_q_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= 4'b0000;
    end else if (clr) begin
      seen <= 4'b0000;
    end else begin
      seen <= seen | comb_bit({a, b});
    end
  end

  assign all_seen = (seen == 4'b1111);

`ifdef PORTA_OR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating count of cycles with y_q high; clr wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_cnt <= '0;
    end else if (clr) begin
      y_cnt <= '0;
    end else if (y_q && (y_cnt != CNT_MAX)) begin
      y_cnt <= y_cnt + CNT_W'(1);
    end
  end
`else
  assign y_cnt = '0;
`endif

endmodule

// File: tb/tb_porta_or_struct.sv
// Directed self-checking bench for porta_or_struct; y_cnt expectations follow PORTA_OR_CNT_EN.
module tb_porta_or_struct;
  import porta_or_pkg::*;

  localparam int unsigned CNT_W = 8;
`ifdef PORTA_OR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             a;
  logic             b;
  logic             clr;
  logic             y;
  logic             y_q;
  logic             y_rise;
  logic [CNT_W-1:0] y_cnt;
  logic [3:0]       seen;
  logic             all_seen;

  int total;
  int bad;

  porta_or_struct #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .clr      (clr),
    .y        (y),
    .y_q      (y_q),
    .y_rise   (y_rise),
    .y_cnt    (y_cnt),
    .seen     (seen),
    .all_seen (all_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ecnt(input int v);
    return CNT_ON ? 32'(v) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic eyq, input logic erise,
                           input logic [31:0] ecount, input logic [3:0] eseen);
    check({tag, ".y_q"},      32'(y_q),      32'(eyq));
    check({tag, ".y_rise"},   32'(y_rise),   32'(erise));
    check({tag, ".y_cnt"},    32'(y_cnt),    ecount);
    check({tag, ".seen"},     32'(seen),     32'(eseen));
    check({tag, ".all_seen"}, 32'(all_seen), 32'(eseen == 4'b1111));
  endtask

  initial begin
    logic [1:0] ab;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a     = 1'b0;
    b     = 1'b0;
    clr   = 1'b0;

    #2;
    check_all("reset", 1'b0, 1'b0, 32'd0, 4'b0000);

    // Truth table during reset, no clock dependency
    ab = COMB_00; {a, b} = ab; #1 check("tt00", 32'(y), 32'd0); #9;
    ab = COMB_01; {a, b} = ab; #1 check("tt01", 32'(y), 32'd1); #9;
    ab = COMB_10; {a, b} = ab; #1 check("tt10", 32'(y), 32'd1); #9;
    ab = COMB_11; {a, b} = ab; #1 check("tt11", 32'(y), 32'd1); #9;
    check_all("reset_hold", 1'b0, 1'b0, 32'd0, 4'b0000);

    // Release with a=1: rise pulse one cycle after y_q goes high
    @(negedge clk);
    rst_n = 1'b1; a = 1'b1; b = 1'b0;
    @(negedge clk); check_all("e1", 1'b1, 1'b0, ecnt(0), 4'b0100);
    @(negedge clk); check_all("e2", 1'b1, 1'b1, ecnt(1), 4'b0100);
    @(negedge clk); check_all("e3", 1'b1, 1'b0, ecnt(2), 4'b0100);

    repeat (300) @(negedge clk);
    check_all("sat", 1'b1, 1'b0, ecnt(255), 4'b0100);

    // Walk remaining combinations to fill the mask
    a = 1'b0; b = 1'b0;
    @(negedge clk); check_all("c00", 1'b0, 1'b0, ecnt(255), 4'b0101);
    a = 1'b0; b = 1'b1;
    @(negedge clk); check_all("c01", 1'b1, 1'b0, ecnt(255), 4'b0111);
    a = 1'b1; b = 1'b1;
    @(negedge clk); check_all("c11", 1'b1, 1'b1, ecnt(255), 4'b1111);

    // clr beats simultaneous increment and set; y_q unaffected
    clr = 1'b1;
    @(negedge clk); check_all("clr", 1'b1, 1'b0, ecnt(0), 4'b0000);
    clr = 1'b0; a = 1'b0; b = 1'b0;
    @(negedge clk); check_all("post_clr", 1'b0, 1'b0, ecnt(1), 4'b0001);

    a = 1'b1; b = 1'b0;
    repeat (5) @(negedge clk);
    check_all("mid", 1'b1, 1'b0, ecnt(5), 4'b0101);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 1'b0, 1'b0, 32'd0, 4'b0000);
    check("async_rst.y", 32'(y), 32'd1);
    a = 1'b0; b = 1'b1; #1 check("rst_y01", 32'(y), 32'd1);
    a = 1'b0; b = 1'b0; #1 check("rst_y00", 32'(y), 32'd0);
    @(negedge clk); check_all("rst_edge", 1'b0, 1'b0, 32'd0, 4'b0000);

    rst_n = 1'b1;
    @(negedge clk); check_all("rel0", 1'b0, 1'b0, ecnt(0), 4'b0001);
    b = 1'b1;
    @(negedge clk); check_all("rel1", 1'b1, 1'b0, ecnt(0), 4'b0011);
    @(negedge clk); check_all("rel2", 1'b1, 1'b1, ecnt(1), 4'b0011);
    @(negedge clk); check_all("rel3", 1'b1, 1'b0, ecnt(2), 4'b0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
